// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Execute-stage front end for the combinational ALU. The stage takes a decoded
// op over a valid/ready handshake and resolves operand bypassing. In the same
// cycle it drives A/B/Gselect to the ALU. It then captures the ALU result with
// its {N,Z,C,V} flags into an EX/MEM register, which is handed downstream over
// a second valid/ready handshake.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               squash: drop the input op, invalidate the output reg
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_gselect          ALU operation code, bit 3 set = logic op
//   in_rs_a/in_rs_b     source register numbers (0 reads as constant zero)
//   in_rd               destination register (0 = no writeback)
//   in_rdata_a/b        register-file read values
//   in_imm/in_use_imm   immediate replaces operand B when in_use_imm=1
//   wb_en/wb_rd/wb_data writeback-stage write, used as a bypass source
//   alu_A/alu_B/alu_Gselect  combinational drive to the ALU
//   alu_G/alu_C/alu_V   ALU result, carry and overflow
//   out_valid/out_ready downstream handshake
//   out_rd/out_result/out_flags  registered destination, result, {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int WIDTH   = 32,
   parameter int RADDR_W = 5,
   parameter int FWD_EN  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_gselect,
   input  logic [RADDR_W-1:0] in_rs_a,
   input  logic [RADDR_W-1:0] in_rs_b,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic [WIDTH-1:0]   in_rdata_a,
   input  logic [WIDTH-1:0]   in_rdata_b,
   input  logic [WIDTH-1:0]   in_imm,
   input  logic               in_use_imm,
   input  logic               wb_en,
   input  logic [RADDR_W-1:0] wb_rd,
   input  logic [WIDTH-1:0]   wb_data,
   output logic [WIDTH-1:0]   alu_A,
   output logic [WIDTH-1:0]   alu_B,
   output logic [3:0]         alu_Gselect,
   input  logic [WIDTH-1:0]   alu_G,
   input  logic               alu_C,
   input  logic               alu_V,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [RADDR_W-1:0] out_rd,
   output logic [WIDTH-1:0]   out_result,
   output logic [3:0]         out_flags
);

   localparam logic L_FWD_ON = (FWD_EN != 0);

   // Operand select: register 0 is hard zero. Otherwise the op still in the
   // output register is newest and beats the writeback stage. This holds even
   // when that op retires on this same edge, because its value is not yet in
   // the register file.
   function automatic logic [WIDTH-1:0] fwd_operand(
      input logic [RADDR_W-1:0] rs,
      input logic [WIDTH-1:0]   rdata,
      input logic               ex_valid,
      input logic [RADDR_W-1:0] ex_rd,
      input logic [WIDTH-1:0]   ex_data,
      input logic               wb_valid,
      input logic [RADDR_W-1:0] wb_dest,
      input logic [WIDTH-1:0]   wb_value
   );
      logic [WIDTH-1:0] v;
      if (rs == {RADDR_W{1'b0}}) begin
         v = {WIDTH{1'b0}};
      end else if (L_FWD_ON && ex_valid && (ex_rd == rs)) begin
         v = ex_data;
      end else if (L_FWD_ON && wb_valid && (wb_dest == rs)) begin
         v = wb_value;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   // Flag packing {N,Z,C,V}. Logic ops (gselect[3]=1) report C and V as zero,
   // whatever the ALU drives on those pins.
   function automatic logic [3:0] calc_flags(
      input logic [WIDTH-1:0] g,
      input logic [3:0]       gsel,
      input logic             c,
      input logic             v
   );
      logic       z;
      logic [3:0] f;
      z = (g == {WIDTH{1'b0}});
      if (gsel[3] == 1'b0) begin
         f = {g[WIDTH-1], z, c, v};
      end else begin
         f = {g[WIDTH-1], z, 1'b0, 1'b0};
      end
      return f;
   endfunction

   logic               r_out_valid;
   logic [RADDR_W-1:0] r_out_rd;
   logic [WIDTH-1:0]   r_out_result;
   logic [3:0]         r_out_flags;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_drain;
   logic [WIDTH-1:0]   w_fwd_a;
   logic [WIDTH-1:0]   w_fwd_b;
   logic [WIDTH-1:0]   w_alu_a;
   logic [WIDTH-1:0]   w_alu_b;
   logic [3:0]         w_alu_gsel;

   // Handshake: the slot is free when empty or emptying this cycle.
   always_comb begin
      w_in_ready = ~r_out_valid | out_ready;
      w_accept   = in_valid & w_in_ready & ~flush;
      w_drain    = r_out_valid & out_ready;
   end

   // Operand resolution and ALU drive. The ALU inputs are quiet when no op is
   // presented.
   always_comb begin
      w_fwd_a = fwd_operand(in_rs_a, in_rdata_a, r_out_valid, r_out_rd,
                            r_out_result, wb_en, wb_rd, wb_data);
      w_fwd_b = fwd_operand(in_rs_b, in_rdata_b, r_out_valid, r_out_rd,
                            r_out_result, wb_en, wb_rd, wb_data);
      if (in_valid) begin
         w_alu_a    = w_fwd_a;
         w_alu_b    = in_use_imm ? in_imm : w_fwd_b;
         w_alu_gsel = in_gselect;
      end else begin
         w_alu_a    = {WIDTH{1'b0}};
         w_alu_b    = {WIDTH{1'b0}};
         w_alu_gsel = 4'b0000;
      end
   end

   // EX/MEM output register. Priority is reset, then flush, then capture, then
   // drain, then hold. Data fields keep their last value when the register
   // becomes invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_rd     <= {RADDR_W{1'b0}};
         r_out_result <= {WIDTH{1'b0}};
         r_out_flags  <= 4'b0000;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_out_rd     <= in_rd;
         r_out_result <= alu_G;
         r_out_flags  <= calc_flags(alu_G, in_gselect, alu_C, alu_V);
      end else if (w_drain) begin
         r_out_valid  <= 1'b0;
      end else begin
         r_out_valid  <= r_out_valid;
      end
   end

   assign in_ready    = w_in_ready;
   assign alu_A       = w_alu_a;
   assign alu_B       = w_alu_b;
   assign alu_Gselect = w_alu_gsel;
   assign out_valid   = r_out_valid;
   assign out_rd      = r_out_rd;
   assign out_result  = r_out_result;
   assign out_flags   = r_out_flags;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed testbench for alu_issue_stage. The bench stands in for the ALU: it
// drives hand-computed alu_G/alu_C/alu_V values for each op. It then checks the
// combinational ALU drive, the bypass selection, and the registered result and
// flags. It also checks the stall, flush and reset behaviour.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam int W = 32;
   localparam int R = 5;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_gselect;
   logic [R-1:0] in_rs_a;
   logic [R-1:0] in_rs_b;
   logic [R-1:0] in_rd;
   logic [W-1:0] in_rdata_a;
   logic [W-1:0] in_rdata_b;
   logic [W-1:0] in_imm;
   logic         in_use_imm;
   logic         wb_en;
   logic [R-1:0] wb_rd;
   logic [W-1:0] wb_data;
   logic [W-1:0] alu_A;
   logic [W-1:0] alu_B;
   logic [3:0]   alu_Gselect;
   logic [W-1:0] alu_G;
   logic         alu_C;
   logic         alu_V;
   logic         out_valid;
   logic         out_ready;
   logic [R-1:0] out_rd;
   logic [W-1:0] out_result;
   logic [3:0]   out_flags;

   int total;
   int bad;

   alu_issue_stage #(.WIDTH(W), .RADDR_W(R), .FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_gselect(in_gselect),
      .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd),
      .in_rdata_a(in_rdata_a), .in_rdata_b(in_rdata_b),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .alu_A(alu_A), .alu_B(alu_B), .alu_Gselect(alu_Gselect),
      .alu_G(alu_G), .alu_C(alu_C), .alu_V(alu_V),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_result(out_result), .out_flags(out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_op(input logic [3:0] gs, input logic [R-1:0] ra, input logic [W-1:0] da,
                         input logic [R-1:0] rb, input logic [W-1:0] db, input logic [R-1:0] rd,
                         input logic [W-1:0] g, input logic c, input logic v);
      in_valid   = 1'b1;
      in_gselect = gs;
      in_rs_a    = ra;
      in_rdata_a = da;
      in_rs_b    = rb;
      in_rdata_b = db;
      in_rd      = rd;
      alu_G      = g;
      alu_C      = c;
      alu_V      = v;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_gselect = 4'h0;
      in_rs_a = '0; in_rs_b = '0; in_rd = '0; in_rdata_a = '0; in_rdata_b = '0;
      in_imm = '0; in_use_imm = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      alu_G = '0; alu_C = 1'b0; alu_V = 1'b0; out_ready = 1'b1;

      // Reset state.
      step(); step();
      rst = 1'b0;
      settle();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_rd", {27'd0, out_rd}, 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_flags", {28'd0, out_flags}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_alu_A", alu_A, 32'd0);
      chk("idle_alu_gsel", {28'd0, alu_Gselect}, 32'd0);

      // Simple add 5+7, no hazard.
      set_op(4'b0010, 5'd1, 32'd5, 5'd2, 32'd7, 5'd5, 32'd12, 1'b0, 1'b0);
      settle();
      chk("add_alu_A", alu_A, 32'd5);
      chk("add_alu_B", alu_B, 32'd7);
      chk("add_alu_gsel", {28'd0, alu_Gselect}, 32'd2);
      step();
      in_valid = 1'b0;
      settle();
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_result", out_result, 32'd12);
      chk("add_rd", {27'd0, out_rd}, 32'd5);
      chk("add_flags", {28'd0, out_flags}, 32'd0);
      step();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back: 0xFFFFFFFF + 1 into r3, then r3 consumed by EX bypass.
      set_op(4'b0001, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 5'd3, 32'd0, 1'b1, 1'b0);
      step();
      set_op(4'b0010, 5'd3, 32'h99, 5'd2, 32'd2, 5'd6, 32'd2, 1'b0, 1'b0);
      settle();
      chk("b2b_op1_flags", {28'd0, out_flags}, 32'h6);
      chk("b2b_op1_result", out_result, 32'd0);
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      chk("b2b_ex_bypass_A", alu_A, 32'd0);
      step();
      chk("b2b_op2_result", out_result, 32'd2);
      chk("b2b_op2_rd", {27'd0, out_rd}, 32'd6);

      // EX bypass of r6 (value 2) beats a WB write to r6; rs_a=0 reads zero.
      set_op(4'b0010, 5'd0, 32'h1234, 5'd6, 32'h55, 5'd7, 32'd2, 1'b0, 1'b0);
      wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h77;
      settle();
      chk("ex_over_wb_B", alu_B, 32'd2);
      chk("rs0_A", alu_A, 32'd0);
      step();
      chk("op3_rd", {27'd0, out_rd}, 32'd7);

      // WB bypass with no EX match, then rs_b=0, then immediate.
      set_op(4'b0010, 5'd1, 32'd1, 5'd4, 32'hAA, 5'd8, 32'h11, 1'b0, 1'b0);
      wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h10;
      settle();
      chk("wb_bypass_B", alu_B, 32'h10);
      in_rs_b = 5'd0;
      settle();
      chk("rs0_B", alu_B, 32'd0);
      in_use_imm = 1'b1; in_imm = 32'h33;
      settle();
      chk("imm_B", alu_B, 32'h33);
      in_valid = 1'b0; in_use_imm = 1'b0; wb_en = 1'b0;
      step();
      chk("drain2_valid", {31'd0, out_valid}, 32'd0);

      // Stall: op5 captured, op6 waits three cycles under out_ready=0.
      set_op(4'b0010, 5'd1, 32'd3, 5'd2, 32'd4, 5'd8, 32'd7, 1'b0, 1'b0);
      step();
      out_ready = 1'b0;
      set_op(4'b0011, 5'd1, 32'd10, 5'd2, 32'd4, 5'd9, 32'd6, 1'b1, 1'b0);
      settle();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_result", out_result, 32'd7);
         chk("stall_rd", {27'd0, out_rd}, 32'd8);
         chk("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      settle();
      chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("unstall_valid", {31'd0, out_valid}, 32'd1);
      chk("unstall_result", out_result, 32'd6);
      chk("unstall_rd", {27'd0, out_rd}, 32'd9);
      chk("unstall_flags", {28'd0, out_flags}, 32'h2);

      // Logic OR: C and V from the ALU must be masked.
      set_op(4'b1010, 5'd1, 32'h8000_0000, 5'd2, 32'd0, 5'd10, 32'h8000_0000, 1'b1, 1'b1);
      step();
      chk("or_result", out_result, 32'h8000_0000);
      chk("or_flags", {28'd0, out_flags}, 32'h8);

      // Flush while stalled with a pending input: valid drops, op is not taken.
      out_ready = 1'b0;
      flush = 1'b1;
      set_op(4'b0010, 5'd1, 32'd2, 5'd2, 32'd3, 5'd11, 32'd5, 1'b0, 1'b0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      settle();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      total++;
      assert (out_rd !== 5'd11) else begin
         bad++;
         $error("FAIL flush_not_captured observed=%h expected=not 0b", out_rd);
      end

      // Reset in the middle of a stall.
      set_op(4'b0010, 5'd1, 32'hDE00, 5'd2, 32'hAD, 5'd12, 32'hDEAD, 1'b1, 1'b1);
      step();
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b0;
      set_op(4'b0010, 5'd1, 32'd1, 5'd2, 32'd1, 5'd13, 32'd2, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      settle();
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_rd", {27'd0, out_rd}, 32'd0);
      chk("mid_rst_result", out_result, 32'd0);
      chk("mid_rst_flags", {28'd0, out_flags}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Execute-stage front end that drives the combinational ALU. It accepts decoded operations over a valid/ready handshake and resolves operand forwarding. It presents A/B/Gselect to the ALU, captures G/C/V plus derived Z/N into an EX/MEM output register, and hands the result downstream over a second valid/ready handshake. It is the initiator side of the ALU interface in the pipelined CPU.

Parameters:
WIDTH, 32, datapath width (A, B, G, immediate, results)
RADDR_W, 5, register-file address width
FWD_EN, 1, 1 enables EX->EX and WB->EX bypass; 0 always uses in_rdata_*

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  squash: drop the input and invalidate the output register
in_valid  input  1  decoded op present
in_ready  output  1  stage can accept an op this cycle
in_gselect  input  4  ALU operation code (same encoding as the ALU's Gselect)
in_rs_a  input  RADDR_W  source register for A
in_rs_b  input  RADDR_W  source register for B
in_rd  input  RADDR_W  destination register (0 = no writeback)
in_rdata_a  input  WIDTH  register-file read value for rs_a
in_rdata_b  input  WIDTH  register-file read value for rs_b
in_imm  input  WIDTH  immediate
in_use_imm  input  1  1: B operand = in_imm
wb_en  input  1  writeback-stage write valid
wb_rd  input  RADDR_W  writeback destination
wb_data  input  WIDTH  writeback value
alu_A  output  WIDTH  ALU operand A
alu_B  output  WIDTH  ALU operand B
alu_Gselect  output  4  ALU operation
alu_G  input  WIDTH  ALU result
alu_C  input  1  ALU carry
alu_V  input  1  ALU overflow
out_valid  output  1  result register holds a valid op
out_ready  input  1  downstream accepts the result
out_rd  output  RADDR_W  registered destination
out_result  output  WIDTH  registered ALU result
out_flags  output  4  registered {N,Z,C,V}

Behaviour:
- Handshake: accept = in_valid & in_ready & ~flush; in_ready = ~out_valid | out_ready (combinational, no bubble on a streaming pipe).
- ALU drive (combinational, same cycle as accept): alu_Gselect = in_gselect; alu_A = fwdA; alu_B = in_use_imm ? in_imm : fwdB. When in_valid=0, drive alu_A=alu_B=0 and alu_Gselect=0.
- Forwarding (per operand, rs = in_rs_x):
  - rs==0 -> operand 0, never forwarded.
  - FWD_EN & out_valid & out_rd==rs -> out_result (highest priority).
  - Else FWD_EN & wb_en & wb_rd==rs -> wb_data.
  - Else in_rdata_x.
- Capture on accept (next edge):
  - out_result=alu_G, out_rd=in_rd, out_valid=1.
  - Flags: if in_gselect[3]==0 (arithmetic) C=alu_C, V=alu_V; else C=0, V=0. Z=(alu_G==0); N=alu_G[WIDTH-1].
- Hold: out_valid & ~out_ready & ~flush -> all out_* hold their values; in_ready=0.
- Drain: out_valid & out_ready & ~accept -> out_valid=0; data fields hold (don't-care).
- Flush: out_valid=0 next edge and the current input is dropped regardless of in_valid/out_ready. Flush has priority over accept and over hold.
- Reset: out_valid=0, out_rd=0, out_result=0, out_flags=0. Reset mid-stall discards the held op. in_ready=1 in the first cycle after reset.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 op/cycle while out_ready=1.
- A forward from out_result is used even when the op in the output register retires in the same cycle.

Test Plan:
- Reset, then in_gselect=0010, A=5, B=7 (no hazard) -> next cycle out_valid=1, out_result=12, flags NZCV=0000.
- Back-to-back: op1 rd=3 = 0xFFFFFFFF+1 (gselect 0001, A via rdata); op2 rs_a=3, in_rdata_a=0x99 -> alu_A=0 (EX bypass); op1 flags Z=1, C=1.
- rs_b=4 with wb_en=1, wb_rd=4, wb_data=0x10 and no EX match -> alu_B=0x10. Same with rs_b=0 -> alu_B=0.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable. out_ready=1 -> the held op retires and the pending op is captured on the same edge.
- Logic op gselect=1010 (OR), A=0x80000000, B=0 with alu_C=1 forced -> out_flags N=1, Z=0, C=0, V=0.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not captured. rst asserted during a stall -> all outputs 0.
